// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control unit.
// FSM sequencing, NZCV flags, condition gating of writes.
module arm_mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] Instr7_4,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB,
      MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] flags;
   logic       condex, condexr;
   logic       hw, dp;
   logic       is_add, is_sub, is_cmp;
   logic       nowrite;
   logic [1:0] flagw;
   logic       nextpc, branch, regw, memw;
   logic       wb_ok, rd15;
   logic       fn, fz, fc, fv;

   assign hw = (Op == 2'b00) & ~Funct[5] & Funct[2]
             & (Instr7_4 == 4'b1011);
   assign dp = (Op == 2'b00) & ~hw;

   assign is_add = (Funct[4:1] == 4'b0100);
   assign is_sub = (Funct[4:1] == 4'b0010);
   assign is_cmp = (Funct[4:1] == 4'b1010);

   assign nowrite  = dp & is_cmp;
   assign flagw[1] = Funct[0];
   assign flagw[0] = Funct[0] & (is_add | is_sub | is_cmp);

   assign {fn, fz, fc, fv} = flags;

   // Condition check of the current instruction against stored flags
   always_comb begin
      condex = 1'b0;
      unique case (Cond)
         4'b0000: condex = fz;
         4'b0001: condex = ~fz;
         4'b0010: condex = fc;
         4'b0011: condex = ~fc;
         4'b0100: condex = fn;
         4'b0101: condex = ~fn;
         4'b0110: condex = fv;
         4'b0111: condex = ~fv;
         4'b1000: condex = fc & ~fz;
         4'b1001: condex = ~fc | fz;
         4'b1010: condex = (fn == fv);
         4'b1011: condex = (fn != fv);
         4'b1100: condex = ~fz & (fn == fv);
         4'b1101: condex = fz | (fn != fv);
         4'b1110: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // Condition latch at end of DECODE; flag update at end of execute
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         condexr <= 1'b0;
         flags   <= 4'b0000;
      end else begin
         if (state == DECODE)
            condexr <= condex;
         if (((state == EXECR) || (state == EXECI)) && condexr) begin
            if (flagw[1]) flags[3:2] <= ALUFlags[3:2];
            if (flagw[0]) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = FETCH;
      unique case (state)
         FETCH:  state_nxt = DECODE;
         DECODE: begin
            unique case (1'b1)
               (Op == 2'b01) | hw:     state_nxt = MEMADR;
               dp & Funct[5]:          state_nxt = EXECI;
               dp & ~Funct[5]:         state_nxt = EXECR;
               (Op == 2'b10):          state_nxt = BRANCH;
               default:                state_nxt = FETCH;
            endcase
         end
         MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_nxt = MEMWB;
         EXECR:  state_nxt = ALUWB;
         EXECI:  state_nxt = ALUWB;
         default: state_nxt = FETCH;
      endcase
   end

   // Raw per-state controls and ALU operation select
   always_comb begin
      nextpc     = 1'b0;
      branch     = 1'b0;
      regw       = 1'b0;
      memw       = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      unique case (state)
         FETCH: begin
            IRWrite   = 1'b1;
            nextpc    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = Funct[3] ? 2'b00 : 2'b01;
         end
         MEMRD: AdrSrc = 1'b1;
         MEMWR: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
         end
         EXECR, EXECI: begin
            ALUSrcB = (state == EXECI) ? 2'b01 : 2'b00;
            unique case (Funct[4:1])
               4'b0100: ALUControl = 2'b00;
               4'b0010: ALUControl = 2'b01;
               4'b0000: ALUControl = 2'b10;
               4'b1100: ALUControl = 2'b11;
               4'b1010: ALUControl = 2'b01;
               default: ALUControl = 2'b00;
            endcase
         end
         ALUWB: regw = 1'b1;
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   assign ImmSrc = hw ? 2'b11 : ((Op == 2'b11) ? 2'b00 : Op);
   assign RegSrc = {(Op == 2'b01) | hw, (Op == 2'b10)};

   assign rd15     = (Rd == 4'd15);
   assign wb_ok    = regw & condexr & ~nowrite;
   assign MemWrite = memw & condexr;
   assign RegWrite = wb_ok & ~rd15;
   assign PCWrite  = nextpc | (branch & condexr) | (wb_ok & rd15);

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: scoreboard bench for arm_mc_controller.
// Expected per-cycle control words are queued per instruction.
module tb_arm_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, Rd, Instr7_4, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   localparam int C_LDR = 0;
   localparam int C_STR = 1;
   localparam int C_DP  = 2;
   localparam int C_B   = 3;
   localparam int C_UND = 4;

   int          errs = 0;
   int          checks = 0;
   logic [15:0] sb[$];
   logic [3:0]  mflags = 4'b0000;
   logic [15:0] obs;

   arm_mc_controller dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
      .Rd(Rd), .Instr7_4(Instr7_4), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .RegSrc(RegSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(
      input logic pcw, mw, rw, irw, adr, asa,
      input logic [1:0] asb, rs, imm, rsrc, alu);
      return {pcw, mw, rw, irw, adr, asa, asb, rs, imm, rsrc, alu};
   endfunction

   // ARM condition: base test on cc[3:1], cc[0] inverts
   function automatic logic cond_ok(input logic [3:0] cc,
                                    input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cc[3:1])
         3'b000:  base = z;
         3'b001:  base = c;
         3'b010:  base = n;
         3'b011:  base = v;
         3'b100:  base = c & ~z;
         3'b101:  base = (n == v);
         3'b110:  base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return cc[0] ? ~base : base;
   endfunction

   function automatic logic [15:0] fetch_vec(input logic [1:0] imm,
                                             input logic [1:0] rsrc);
      return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                2'b10, 2'b10, imm, rsrc, 2'b00);
   endfunction

   // Drive one instruction (entered at a falling edge in FETCH),
   // queue its expected control words, then check them cycle by cycle.
   task automatic run(input string tag, input int cls,
                      input logic [3:0] cc, input logic [1:0] op,
                      input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] i74, input logic [3:0] af,
                      input logic [1:0] aluc, input logic nw,
                      input logic [1:0] fw, input int ncheck);
      logic c, hw, r15;
      logic [1:0] imm, rsrc, ua, isb;
      int k;
      bit cut;
      Cond = cc; Op = op; Funct = fn; Rd = rd;
      Instr7_4 = i74; ALUFlags = af;
      c    = cond_ok(cc, mflags);
      hw   = ((cls == C_LDR) || (cls == C_STR)) && (op == 2'b00);
      imm  = hw ? 2'b11 : ((op == 2'b11) ? 2'b00 : op);
      rsrc = {(op == 2'b01) || hw, op == 2'b10};
      r15  = (rd == 4'd15);
      ua   = fn[3] ? 2'b00 : 2'b01;
      isb  = fn[5] ? 2'b01 : 2'b00;
      sb.push_back(fetch_vec(imm, rsrc));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      2'b10, 2'b10, imm, rsrc, 2'b00));
      case (cls)
         C_LDR: begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            2'b01, 2'b00, imm, rsrc, ua));
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                            2'b00, 2'b00, imm, rsrc, 2'b00));
            sb.push_back(mk(c & r15, 1'b0, c & ~r15, 1'b0, 1'b0, 1'b0,
                            2'b00, 2'b01, imm, rsrc, 2'b00));
         end
         C_STR: begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            2'b01, 2'b00, imm, rsrc, ua));
            sb.push_back(mk(1'b0, c, 1'b0, 1'b0, 1'b1, 1'b0,
                            2'b00, 2'b00, imm, rsrc, 2'b00));
         end
         C_DP: begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            isb, 2'b00, imm, rsrc, aluc));
            sb.push_back(mk(c & ~nw & r15, 1'b0, c & ~nw & ~r15,
                            1'b0, 1'b0, 1'b0,
                            2'b00, 2'b00, imm, rsrc, 2'b00));
         end
         C_B: begin
            sb.push_back(mk(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            2'b01, 2'b10, imm, rsrc, 2'b00));
         end
         default: ;
      endcase
      if (cls == C_DP && c) begin
         if (fw[1]) mflags[3:2] = af[3:2];
         if (fw[0]) mflags[1:0] = af[1:0];
      end
      #1;
      k = 0;
      cut = 1'b0;
      while (sb.size() > 0) begin
         if (k >= ncheck) begin
            sb.delete();
            cut = 1'b1;
         end else begin
            if (k > 0) begin
               @(negedge clk);
               #1;
            end
            chk($sformatf("%s[%0d]", tag, k), obs, sb.pop_front());
            k++;
         end
      end
      if (!cut) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      Cond = 4'hE; Op = 2'b00; Funct = 6'b001001;
      Rd = 4'd1; Instr7_4 = 4'h0; ALUFlags = 4'h0;
      #1;
      chk("rst_async", obs, fetch_vec(2'b00, 2'b00));
      @(negedge clk); #1;
      chk("rst_held", obs, fetch_vec(2'b00, 2'b00));
      @(negedge clk);
      reset = 1'b0;

      run("adds", C_DP, 4'hE, 2'b00, 6'b001001, 4'd1, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b11, 99);
      run("beq_nt", C_B, 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("subs", C_DP, 4'hE, 2'b00, 6'b000101, 4'd2, 4'h0, 4'b0100,
          2'b01, 1'b0, 2'b11, 99);
      run("beq_t", C_B, 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("ldr", C_LDR, 4'hE, 2'b01, 6'b010001, 4'd2, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("str", C_STR, 4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("ldrh", C_LDR, 4'hE, 2'b00, 6'b010101, 4'd3, 4'b1011, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("cmp", C_DP, 4'hE, 2'b00, 6'b010101, 4'd0, 4'h0, 4'b1000,
          2'b01, 1'b1, 2'b11, 99);
      run("bmi_t", C_B, 4'h4, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("beq_nt2", C_B, 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("orreq_fail", C_DP, 4'h0, 2'b00, 6'b011000, 4'd4, 4'h0, 4'hF,
          2'b11, 1'b0, 2'b00, 99);
      run("add_pc", C_DP, 4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("andi", C_DP, 4'hE, 2'b00, 6'b100000, 4'd5, 4'h0, 4'h0,
          2'b10, 1'b0, 2'b00, 99);
      run("add_nv", C_DP, 4'hF, 2'b00, 6'b001000, 4'd6, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("undef", C_UND, 4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("streq_fail", C_STR, 4'h0, 2'b01, 6'b011000, 4'd3, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("ldr_abort", C_LDR, 4'hE, 2'b01, 6'b010001, 4'd7, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 4);

      #2;
      reset = 1'b1;
      mflags = 4'b0000;
      #1;
      chk("abort_async", obs, fetch_vec(2'b01, 2'b10));
      @(negedge clk); #1;
      chk("abort_held", obs, fetch_vec(2'b01, 2'b10));
      @(negedge clk);
      reset = 1'b0;

      run("bne_t", C_B, 4'h1, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      run("beq_clr", C_B, 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0,
          2'b00, 1'b0, 2'b00, 99);
      #1;
      chk("final_fetch", obs, fetch_vec(2'b10, 2'b01));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
